// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a registered ALU top.
// Takes one operation per valid/ready command, holds the operands steady on the
// ALU inputs for the pipeline latency, captures result and flags, and holds the
// response until the host consumes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; alu_* keep the last command issued
// WAIT    | operands held on the ALU, counting down the pipeline delay
// CAPTURE | ALU output valid; result and flags latched at closing edge
// RESP    | response held until rsp_ready, then op_count advances
module alu_cmd_sequencer #(
  parameter int N       = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_op,
  input  logic [N-1:0]     alu_r,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_r,
  output logic [3:0]       rsp_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int WC_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WC_W-1:0] LAT_V  = WC_W'(LATENCY);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_r_q, rsp_r_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state and register updates; everything holds unless the state acts on it.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          wcnt_d   = LAT_V;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A zero count can only come from a degenerate LATENCY; treat it as done.
        if (wcnt_q <= WC_ONE) begin
          wcnt_d  = '0;
          state_d = S_CAPTURE;
        end else begin
          wcnt_d = wcnt_q - WC_ONE;
        end
      end
      S_CAPTURE: begin
        rsp_r_d     = alu_r;
        rsp_flags_d = {alu_c, alu_z, alu_n, alu_v};
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is gated by reset so the host never sees ready while held in reset.
  assign cmd_ready = (state_q == S_IDLE) && rst;
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer driving a two-stage registered ALU stub.
// Stub: op 4'hF forces r=0 with c=1,z=1; any other op gives r=a^b,
// c=0, z=(r==0), n=r[3], v=0.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_op;
  logic [3:0] alu_a, alu_b, alu_op, alu_r;
  logic       alu_c, alu_z, alu_n, alu_v;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_r, rsp_flags;
  logic [1:0] op_count;
  logic       busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  typedef struct {
    logic [3:0] r;
    logic [3:0] f;
    int         acc;
  } exp_t;
  exp_t exq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.N(4), .LATENCY(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags),
    .op_count(op_count), .busy(busy)
  );

  // ALU stub: input register then output register (two-edge latency)
  logic [3:0] sa = '0, sb = '0, so = '0;
  logic [3:0] nr;
  always @(posedge clk) begin
    sa <= alu_a;
    sb <= alu_b;
    so <= alu_op;
    if (so == 4'hF) begin
      alu_r <= 4'h0; alu_c <= 1'b1; alu_z <= 1'b1; alu_n <= 1'b0; alu_v <= 1'b0;
    end else begin
      nr = sa ^ sb;
      alu_r <= nr; alu_c <= 1'b0; alu_z <= (nr == 4'h0); alu_n <= nr[3]; alu_v <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: checks every cycle a response is held, latency on its
  // first cycle, and op_count one cycle after each consumption.
  logic [1:0] exp_cnt = '0;
  logic       prev_v  = 1'b0;
  logic       chk_cnt = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_cnt = '0;
      prev_v  = 1'b0;
      chk_cnt = 1'b0;
    end else begin
      if (chk_cnt) begin
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk_cnt = 1'b0;
      end
      if (rsp_valid) begin
        if (exq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_r), 32'hFFFF_FFFF);
        end else begin
          if (!prev_v) chk("rsp_latency", 32'(cyc - exq[0].acc), 32'd3);
          chk("rsp_r", 32'(rsp_r), 32'(exq[0].r));
          chk("rsp_flags", 32'(rsp_flags), 32'(exq[0].f));
          if (rsp_ready) begin
            void'(exq.pop_front());
            exp_cnt = exp_cnt + 2'd1;
            chk_cnt = 1'b1;
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       input logic [3:0] er, input logic [3:0] ef, output int acc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    exq.push_back('{r: er, f: ef, acc: acc});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [3:0] va[5] = '{4'hA, 4'h3, 4'h7, 4'hC, 4'h1};
  logic [3:0] vb[5] = '{4'h5, 4'h3, 4'h1, 4'h4, 4'hE};
  logic [3:0] vr[5] = '{4'hF, 4'h0, 4'h6, 4'h8, 4'hF};
  logic [3:0] vf[5] = '{4'b0010, 4'b0100, 4'b0000, 4'b0010, 4'b0010};

  initial begin
    int acc, last_acc, n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // single XOR op
    issue(4'h5, 4'h3, 4'h0, 4'h6, 4'b0000, acc);
    wait_idle();

    // forced-flag op
    issue(4'hC, 4'h3, 4'hF, 4'h0, 4'b1100, acc);
    wait_idle();

    // operand stability while cmd_a changes during WAIT
    issue(4'h9, 4'h2, 4'h0, 4'hB, 4'b0010, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_a_stable", 32'(alu_a), 32'h9);
      chk("alu_b_stable", 32'(alu_b), 32'h2);
      cmd_a = 4'(i + 1);
    end
    wait_idle();

    // reset during WAIT aborts the op
    issue(4'h7, 4'h2, 4'h0, 4'h5, 4'b0000, acc);
    @(negedge clk) rst = 1'b0;
    #1;
    void'(exq.pop_back());
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_alu_op", 32'(alu_op), 32'd0);
    chk("abort_rsp_r", 32'(rsp_r), 32'd0);
    chk("abort_op_count", 32'(op_count), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("abort_rel_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

    // back-to-back ops, interval and counter wrap
    last_acc = 0;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], 4'h0, vr[i], vf[i], acc);
      if (i > 0) chk("issue_interval", 32'(acc - last_acc), 32'd5);
      last_acc = acc;
    end
    wait_idle();
    chk("wrap_op_count", 32'(op_count), 32'd1);

    // backpressure: response held, new commands ignored
    rsp_ready = 1'b0;
    issue(4'h2, 4'h8, 4'h0, 4'hA, 4'b0010, acc);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 4'(i); cmd_b = 4'hF;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    repeat (6) @(negedge clk);
    chk("bp_single_done", 32'(op_count), 32'd2);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
